// File: rtl/matrix_store_pkg.sv
// Shared codes for matrix_store: access types, matrix IDs and the read-FSM states.
// Code 2'b11 is illegal for both the access type and the matrix select.
package matrix_store_pkg;

    typedef enum logic [1:0] {
        ACC_CELL = 2'b00,
        ACC_ROW  = 2'b01,
        ACC_COL  = 2'b10
    } access_t;

    typedef enum logic [1:0] {
        MAT_A = 2'b00,
        MAT_B = 2'b01,
        MAT_C = 2'b10
    } matrix_t;

    localparam logic [1:0] CODE_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GATHER,
        ST_READY,
        ST_RELEASE
    } read_state_t;

    function automatic logic code_legal(input logic [1:0] acc_type, input logic [1:0] mat);
        return (acc_type != CODE_ILLEGAL) && (mat != CODE_ILLEGAL);
    endfunction

endpackage

// File: rtl/matrix_bank.sv
// One size x size matrix of cells: combinational single-cell read port,
// write port that updates one cell, one row or one column per edge.
module matrix_bank
    import matrix_store_pkg::*;
#(
    parameter int size          = 4,
    parameter int cell_width    = 32,
    parameter int address_width = 4,
    parameter int width         = cell_width * size,
    parameter int index_width   = (size * size > 1) ? $clog2(size * size) : 1
) (
    input  logic                     in_clk,
    input  logic                     in_reset,
    input  logic [index_width-1:0]   in_rd_index,
    output logic [cell_width-1:0]    out_rd_data,
    input  logic                     in_write_en,
    input  logic [1:0]               in_type,
    input  logic [address_width-1:0] in_reg_address,
    input  logic [width-1:0]         in_data
);

    localparam int CELLS = size * size;

    logic [cell_width-1:0] cells [CELLS];
    int unsigned           wr_addr;

    assign wr_addr     = 32'(in_reg_address);
    assign out_rd_data = cells[in_rd_index];

    for (genvar r = 0; r < size; r++) begin : g_row
        for (genvar c = 0; c < size; c++) begin : g_col
            logic [cell_width-1:0] cell_q;
            logic [cell_width-1:0] wval;
            logic                  hit;

            // A row write places column c at lane c; a column write places row r at lane r.
            always_comb begin
                hit  = 1'b0;
                wval = in_data[cell_width-1:0];
                case (in_type)
                    ACC_CELL: hit = (wr_addr == 32'(r * size + c));
                    ACC_ROW: begin
                        hit  = (wr_addr / size == 32'(r));
                        wval = in_data[c*cell_width +: cell_width];
                    end
                    ACC_COL: begin
                        hit  = (wr_addr % size == 32'(c));
                        wval = in_data[r*cell_width +: cell_width];
                    end
                    default: hit = 1'b0;
                endcase
            end

            always_ff @(posedge in_clk) begin
                if (in_reset) begin
                    cell_q <= '0;
                end else if (in_write_en && hit) begin
                    cell_q <= wval;
                end
            end

            assign cells[r*size+c] = cell_q;
        end
    end

endmodule

// File: rtl/matrix_store.sv
// Three-matrix register store (A, B, C) with cell/row/column writes and a
// multi-cycle read FSM that gathers one cell per clock into out_data.
module matrix_store
    import matrix_store_pkg::*;
#(
    parameter int size          = 4,
    parameter int cell_width    = 32,
    parameter int address_width = 4,
    parameter int width         = cell_width * size
) (
    input  logic                     in_clk,
    input  logic                     in_reset,
    input  logic [address_width-1:0] in_reg_address,
    input  logic [1:0]               in_type,
    input  logic [1:0]               in_matrix,
    input  logic                     in_read_en,
    input  logic                     in_write_en,
    input  logic [width-1:0]         in_data,
    output logic [width-1:0]         out_data,
    output logic                     out_data_ready,
    output logic                     out_error
);

    localparam int CELLS = size * size;
    localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam int CNT_W = (size > 1) ? $clog2(size) : 1;

    read_state_t              state, state_nx;
    logic [address_width-1:0] lat_addr, lat_addr_nx;
    logic [1:0]               lat_type, lat_type_nx;
    logic [1:0]               lat_mat, lat_mat_nx;
    logic [CNT_W-1:0]         cnt, cnt_nx;
    logic [width-1:0]         data_q, data_nx;
    logic                     ready_q, ready_nx;
    logic                     err_q, err_nx;

    logic                     req_legal;
    int unsigned              rd_idx;
    int unsigned              last_cnt;
    logic [cell_width-1:0]    bank_rd [3];
    logic [cell_width-1:0]    rd_cell;
    logic [2:0]               wr_sel;

    assign req_legal = code_legal(in_type, in_matrix);

    always_comb begin
        wr_sel = '0;
        if (in_write_en && req_legal) begin
            case (in_matrix)
                MAT_A:   wr_sel[0] = 1'b1;
                MAT_B:   wr_sel[1] = 1'b1;
                MAT_C:   wr_sel[2] = 1'b1;
                default: wr_sel = '0;
            endcase
        end
    end

    for (genvar m = 0; m < 3; m++) begin : g_bank
        matrix_bank #(
            .size          (size),
            .cell_width    (cell_width),
            .address_width (address_width),
            .width         (width),
            .index_width   (IDX_W)
        ) u_bank (
            .in_clk         (in_clk),
            .in_reset       (in_reset),
            .in_rd_index    (IDX_W'(rd_idx)),
            .out_rd_data    (bank_rd[m]),
            .in_write_en    (wr_sel[m]),
            .in_type        (in_type),
            .in_reg_address (in_reg_address),
            .in_data        (in_data)
        );
    end

    // Cell visited on this gather step, from the latched request.
    always_comb begin
        rd_idx   = 32'(lat_addr);
        last_cnt = 32'(size - 1);
        case (lat_type)
            ACC_ROW: rd_idx = (32'(lat_addr) / size) * size + 32'(cnt);
            ACC_COL: rd_idx = 32'(cnt) * size + 32'(lat_addr) % size;
            default: last_cnt = 0;
        endcase
    end

    always_comb begin
        rd_cell = '0;
        if (rd_idx < CELLS) begin
            case (lat_mat)
                MAT_A:   rd_cell = bank_rd[0];
                MAT_B:   rd_cell = bank_rd[1];
                MAT_C:   rd_cell = bank_rd[2];
                default: rd_cell = '0;
            endcase
        end
    end

    always_comb begin
        state_nx    = state;
        lat_addr_nx = lat_addr;
        lat_type_nx = lat_type;
        lat_mat_nx  = lat_mat;
        cnt_nx      = cnt;
        data_nx     = data_q;
        ready_nx    = 1'b0;
        err_nx      = in_write_en && !req_legal;

        case (state)
            ST_IDLE: begin
                if (in_read_en) begin
                    lat_addr_nx = in_reg_address;
                    lat_type_nx = in_type;
                    lat_mat_nx  = in_matrix;
                    cnt_nx      = '0;
                    data_nx     = '0;
                    // Illegal reads complete immediately with zero data.
                    if (req_legal) begin
                        state_nx = ST_GATHER;
                    end else begin
                        ready_nx = 1'b1;
                        err_nx   = 1'b1;
                        state_nx = ST_READY;
                    end
                end
            end
            ST_GATHER: begin
                data_nx[32'(cnt)*cell_width +: cell_width] = rd_cell;
                if (32'(cnt) == last_cnt) begin
                    ready_nx = 1'b1;
                    state_nx = ST_READY;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            ST_READY: state_nx = ST_RELEASE;
            ST_RELEASE: begin
                if (!in_read_en) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            state    <= ST_IDLE;
            lat_addr <= '0;
            lat_type <= '0;
            lat_mat  <= '0;
            cnt      <= '0;
            data_q   <= '0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nx;
            lat_addr <= lat_addr_nx;
            lat_type <= lat_type_nx;
            lat_mat  <= lat_mat_nx;
            cnt      <= cnt_nx;
            data_q   <= data_nx;
            ready_q  <= ready_nx;
            err_q    <= err_nx;
        end
    end

    assign out_data       = data_q;
    assign out_data_ready = ready_q;
    assign out_error      = err_q;

endmodule

// File: tb/tb_matrix_store.sv
// Bench for matrix_store: directed vector table, hand-written multi-cycle
// sequences and randomized accesses checked against an array model.
module tb_matrix_store;

    localparam int SIZE = 4;
    localparam int CW   = 32;
    localparam int AW   = 4;
    localparam int W    = CW * SIZE;

    logic          clk = 1'b0;
    logic          in_reset;
    logic [AW-1:0] in_reg_address;
    logic [1:0]    in_type;
    logic [1:0]    in_matrix;
    logic          in_read_en;
    logic          in_write_en;
    logic [W-1:0]  in_data;
    logic [W-1:0]  out_data;
    logic          out_data_ready;
    logic          out_error;

    int total = 0;
    int bad   = 0;

    logic [CW-1:0] model [3][SIZE*SIZE];

    always #5 clk = ~clk;

    matrix_store #(
        .size          (SIZE),
        .cell_width    (CW),
        .address_width (AW),
        .width         (W)
    ) dut (
        .in_clk         (clk),
        .in_reset       (in_reset),
        .in_reg_address (in_reg_address),
        .in_type        (in_type),
        .in_matrix      (in_matrix),
        .in_read_en     (in_read_en),
        .in_write_en    (in_write_en),
        .in_data        (in_data),
        .out_data       (out_data),
        .out_data_ready (out_data_ready),
        .out_error      (out_error)
    );

    typedef struct {
        bit           wr;
        logic [1:0]   mat;
        logic [1:0]   typ;
        logic [3:0]   addr;
        logic [W-1:0] data;
        logic [W-1:0] exp;
        int           lat;
        bit           err;
    } vec_t;

    function automatic vec_t mk(bit wr, logic [1:0] mat, logic [1:0] typ, logic [3:0] addr,
                                logic [W-1:0] data, logic [W-1:0] exp, int lat, bit err);
        vec_t v;
        v.wr = wr; v.mat = mat; v.typ = typ; v.addr = addr;
        v.data = data; v.exp = exp; v.lat = lat; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    function automatic bit legal(input logic [1:0] mat, input logic [1:0] typ);
        return (mat != 2'b11) && (typ != 2'b11);
    endfunction

    function automatic logic [W-1:0] model_read(input logic [1:0] mat, input logic [1:0] typ,
                                                input logic [3:0] addr);
        logic [W-1:0] v;
        int a;
        v = '0;
        a = int'(addr);
        if (legal(mat, typ)) begin
            if (typ == 2'b00) v[CW-1:0] = model[mat][a];
            else if (typ == 2'b01) for (int i = 0; i < SIZE; i++) v[i*CW +: CW] = model[mat][(a / SIZE) * SIZE + i];
            else for (int i = 0; i < SIZE; i++) v[i*CW +: CW] = model[mat][i * SIZE + a % SIZE];
        end
        return v;
    endfunction

    task automatic model_write(input logic [1:0] mat, input logic [1:0] typ, input logic [3:0] addr,
                               input logic [W-1:0] data);
        int a;
        a = int'(addr);
        if (legal(mat, typ)) begin
            if (typ == 2'b00) model[mat][a] = data[CW-1:0];
            else if (typ == 2'b01) for (int i = 0; i < SIZE; i++) model[mat][(a / SIZE) * SIZE + i] = data[i*CW +: CW];
            else for (int i = 0; i < SIZE; i++) model[mat][i * SIZE + a % SIZE] = data[i*CW +: CW];
        end
    endtask

    task automatic model_clear();
        for (int m = 0; m < 3; m++)
            for (int i = 0; i < SIZE * SIZE; i++) model[m][i] = '0;
    endtask

    task automatic wait_ready(output int lat);
        lat = 0;
        while (!out_data_ready && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic do_write(input logic [1:0] mat, input logic [1:0] typ, input logic [3:0] addr,
                            input logic [W-1:0] data, input bit exp_err, input string name);
        @(negedge clk);
        in_matrix = mat; in_type = typ; in_reg_address = addr; in_data = data; in_write_en = 1'b1;
        @(posedge clk); #1;
        in_write_en = 1'b0;
        model_write(mat, typ, addr, data);
        chk({name, ".err"}, W'(out_error), W'(exp_err));
    endtask

    task automatic do_read(input logic [1:0] mat, input logic [1:0] typ, input logic [3:0] addr,
                           input logic [W-1:0] exp, input int exp_lat, input bit exp_err, input string name);
        int lat;
        @(negedge clk);
        in_matrix = mat; in_type = typ; in_reg_address = addr; in_read_en = 1'b1;
        @(posedge clk); #1;
        wait_ready(lat);
        chk({name, ".lat"}, W'(lat), W'(exp_lat));
        chk({name, ".data"}, out_data, exp);
        chk({name, ".err"}, W'(out_error), W'(exp_err));
        in_read_en = 1'b0;
        @(posedge clk); #1;
        chk({name, ".pulse"}, W'(out_data_ready), '0);
        chk({name, ".hold"}, out_data, exp);
        @(posedge clk); #1;
    endtask

    vec_t tbl[16];

    initial begin
        int lat;
        int pulses;
        logic [W-1:0] old;
        logic [1:0] mat, typ;
        logic [3:0] addr;
        logic [W-1:0] data;

        tbl[0]  = mk(1, 2'b00, 2'b01, 4'd4,  {32'd4, 32'd3, 32'd2, 32'd1}, '0, 0, 0);
        tbl[1]  = mk(0, 2'b00, 2'b01, 4'd5,  '0, {32'd4, 32'd3, 32'd2, 32'd1}, 4, 0);
        tbl[2]  = mk(1, 2'b01, 2'b00, 4'd2,  W'(10), '0, 0, 0);
        tbl[3]  = mk(1, 2'b01, 2'b00, 4'd6,  W'(11), '0, 0, 0);
        tbl[4]  = mk(1, 2'b01, 2'b00, 4'd10, W'(12), '0, 0, 0);
        tbl[5]  = mk(1, 2'b01, 2'b00, 4'd14, W'(13), '0, 0, 0);
        tbl[6]  = mk(0, 2'b01, 2'b10, 4'd2,  '0, {32'd13, 32'd12, 32'd11, 32'd10}, 4, 0);
        tbl[7]  = mk(1, 2'b10, 2'b00, 4'd6,  W'(32'h3F80_0000), '0, 0, 0);
        tbl[8]  = mk(0, 2'b10, 2'b00, 4'd6,  '0, W'(32'h3F80_0000), 1, 0);
        tbl[9]  = mk(0, 2'b11, 2'b01, 4'd0,  '0, '0, 0, 1);
        tbl[10] = mk(1, 2'b00, 2'b11, 4'd0,  '1, '0, 0, 1);
        tbl[11] = mk(0, 2'b00, 2'b01, 4'd0,  '0, '0, 4, 0);
        tbl[12] = mk(0, 2'b00, 2'b10, 4'd1,  '0, {32'd0, 32'd0, 32'd2, 32'd0}, 4, 0);
        tbl[13] = mk(0, 2'b10, 2'b01, 4'd5,  '0, {32'd0, 32'h3F80_0000, 32'd0, 32'd0}, 4, 0);
        tbl[14] = mk(1, 2'b00, 2'b10, 4'd3,  {32'd8, 32'd7, 32'd6, 32'd5}, '0, 0, 0);
        tbl[15] = mk(0, 2'b00, 2'b01, 4'd4,  '0, {32'd6, 32'd3, 32'd2, 32'd1}, 4, 0);

        in_reset = 1'b1; in_reg_address = '0; in_type = '0; in_matrix = '0;
        in_read_en = 1'b0; in_write_en = 1'b0; in_data = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("reset.data", out_data, '0);
        chk("reset.ready", W'(out_data_ready), '0);
        chk("reset.err", W'(out_error), '0);
        @(negedge clk);
        in_reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            if (tbl[i].wr)
                do_write(tbl[i].mat, tbl[i].typ, tbl[i].addr, tbl[i].data, tbl[i].err, $sformatf("vec%0d", i));
            else
                do_read(tbl[i].mat, tbl[i].typ, tbl[i].addr, tbl[i].exp, tbl[i].lat, tbl[i].err, $sformatf("vec%0d", i));
        end

        // Write to the cell being gathered on the same edge: old value is read.
        old = model_read(2'b00, 2'b00, 4'd5);
        @(negedge clk);
        in_matrix = 2'b00; in_type = 2'b00; in_reg_address = 4'd5; in_read_en = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        in_data = W'(99); in_write_en = 1'b1;
        @(posedge clk); #1;
        in_write_en = 1'b0;
        model_write(2'b00, 2'b00, 4'd5, W'(99));
        chk("wr_gather.ready", W'(out_data_ready), W'(1));
        chk("wr_gather.data", out_data, old);
        in_read_en = 1'b0;
        repeat (2) @(posedge clk);
        do_read(2'b00, 2'b00, 4'd5, W'(99), 1, 0, "wr_gather.after");

        // Read and write together in IDLE.
        @(negedge clk);
        in_matrix = 2'b01; in_type = 2'b00; in_reg_address = 4'd0; in_data = W'(77);
        in_read_en = 1'b1; in_write_en = 1'b1;
        @(posedge clk); #1;
        in_write_en = 1'b0;
        model_write(2'b01, 2'b00, 4'd0, W'(77));
        wait_ready(lat);
        chk("rdwr.lat", W'(lat), W'(1));
        chk("rdwr.data", out_data, W'(77));
        in_read_en = 1'b0;
        repeat (2) @(posedge clk);

        // Held request yields a single read; a one-cycle drop re-arms it.
        @(negedge clk);
        in_matrix = 2'b00; in_type = 2'b01; in_reg_address = 4'd4; in_read_en = 1'b1;
        pulses = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_data_ready) pulses++;
        end
        chk("hold.pulses", W'(pulses), W'(1));
        chk("hold.data", out_data, model_read(2'b00, 2'b01, 4'd4));
        @(negedge clk);
        in_read_en = 1'b0;
        @(negedge clk);
        in_read_en = 1'b1;
        pulses = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_data_ready) pulses++;
        end
        chk("rearm.pulses", W'(pulses), W'(1));
        in_read_en = 1'b0;
        repeat (2) @(posedge clk);

        // Reset mid-gather, with a write on the reset edge.
        @(negedge clk);
        in_matrix = 2'b00; in_type = 2'b01; in_reg_address = 4'd4; in_read_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        in_reset = 1'b1; in_read_en = 1'b0;
        in_type = 2'b00; in_reg_address = 4'd0; in_data = W'(5); in_write_en = 1'b1;
        @(posedge clk); #1;
        in_write_en = 1'b0;
        model_clear();
        chk("rst_mid.ready", W'(out_data_ready), '0);
        chk("rst_mid.data", out_data, '0);
        @(negedge clk);
        in_reset = 1'b0;
        pulses = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_data_ready) pulses++;
        end
        chk("rst_mid.pulses", W'(pulses), '0);
        do_read(2'b00, 2'b01, 4'd4, '0, 4, 0, "rst_mid.row1");
        do_read(2'b00, 2'b00, 4'd0, '0, 1, 0, "rst_mid.cell0");
        do_read(2'b10, 2'b00, 4'd6, '0, 1, 0, "rst_mid.c6");

        // Randomized accesses against the array model.
        for (int n = 0; n < 80; n++) begin
            mat  = ($urandom_range(0, 11) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            typ  = ($urandom_range(0, 11) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            addr = 4'($urandom_range(0, 15));
            data = {$urandom(), $urandom(), $urandom(), $urandom()};
            if ($urandom_range(0, 1) == 0)
                do_write(mat, typ, addr, data, !legal(mat, typ), $sformatf("rnd%0d.w", n));
            else
                do_read(mat, typ, addr, model_read(mat, typ, addr),
                        !legal(mat, typ) ? 0 : (typ == 2'b00 ? 1 : SIZE),
                        !legal(mat, typ), $sformatf("rnd%0d.r", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/matrix_store.md
MATRIX_STORE -- requirements
Module: matrix_store

Interface
REQ-001 SHALL have parameters: size, default 4, matrix dimension; cell_width, default 32, bits per cell; address_width, default 4, cell address bits; width, default cell_width*size, row/column bus width.
REQ-002 SHALL have port in_clk, input, 1, the single clock.
REQ-003 SHALL have port in_reset, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port in_reg_address, input, address_width, row-major cell address (row*size+col).
REQ-005 SHALL have port in_type, input, 2, access type: 00 cell, 01 row, 10 column.
REQ-006 SHALL have port in_matrix, input, 2, matrix select: 00 A, 01 B, 10 C.
REQ-007 SHALL have ports in_read_en and in_write_en, input, 1 each, read request level and write strobe.
REQ-008 SHALL have port in_data, input, width, write data.
REQ-009 SHALL have port out_data, output, width, read data.
REQ-010 SHALL have port out_data_ready, output, 1, one-cycle read-complete pulse.
REQ-011 SHALL have port out_error, output, 1, one-cycle illegal-access pulse.

Function
REQ-012 SHALL store three size x size matrices (A, B, C) of cell_width-bit cells.
REQ-013 Row access SHALL use row = in_reg_address / size; column access SHALL use col = in_reg_address mod size; cell access SHALL use the full address.
REQ-014 Row and column data SHALL be packed with cell i (i-th column of a row, i-th row of a column) at bits [i*cell_width +: cell_width]; cell data SHALL occupy bits [cell_width-1:0], upper bits zero.
REQ-015 Read FSM SHALL have states IDLE, GATHER, READY, RELEASE.
REQ-016 IDLE: on in_read_en=1 at an edge, SHALL latch address, type and matrix, clear out_data, clear the cell counter, and go to GATHER.
REQ-017 GATHER: SHALL copy one cell per edge into out_data; after n edges (n = size for row/column, 1 for cell) SHALL set out_data_ready=1 and go to READY.
REQ-018 READY: at the next edge SHALL clear out_data_ready and go to RELEASE; out_data_ready SHALL be high for exactly one cycle per request.
REQ-019 RELEASE: SHALL hold out_data and return to IDLE on the first edge where in_read_en=0; a request held high SHALL NOT start a second read.
REQ-020 out_data SHALL remain stable from the rising of out_data_ready until the next request is accepted.
REQ-021 Writes SHALL be accepted in every FSM state on in_write_en=1 and take effect at that edge: cell writes in_data[cell_width-1:0]; row or column writes all size cells from in_data per REQ-014 packing.
REQ-022 A write to a cell being gathered in the same edge SHALL return the old value.
REQ-023 Simultaneous in_read_en and in_write_en in IDLE SHALL perform the write and accept the read.
REQ-024 in_type=11 or in_matrix=11 SHALL not modify storage and SHALL pulse out_error for one cycle. On a read, out_data SHALL be 0 and out_data_ready SHALL pulse in the same cycle as out_error, via READY with no GATHER.

Reset
REQ-025 in_reset=1 at an edge SHALL clear all storage to 0 and set out_data=0, out_data_ready=0, out_error=0, counter=0, and state IDLE.
REQ-026 Reset mid-GATHER or mid-RELEASE SHALL abort the request with no out_data_ready pulse.
REQ-027 Reset SHALL take priority over simultaneous reads and writes.

Structure
REQ-028 A shared package SHALL hold the access-type codes (CELL, ROW, COL), the matrix IDs (A, B, C) and the read-FSM state encoding.
REQ-029 Storage SHALL be one sub-module, matrix_bank, instantiated three times, each with a cell read port and a cell/row/column write port.

Verification
REQ-030 Write row type, A, address 4, cells {1,2,3,4}; read row, address 5: out_data cells 1,2,3,4; out_data_ready high one cycle, 4 edges after acceptance.
REQ-031 Cell-write B[r][2]=10+r for r=0..3; read column, B, address 2: cells 10,11,12,13.
REQ-032 Cell-write C address 6 = 0x3F800000; cell read: out_data low cell 0x3F800000, upper bits 0, ready 1 edge after acceptance.
REQ-033 Hold in_read_en high 10 cycles: exactly one ready pulse; drop it 1 cycle then reassert: second read accepted.
REQ-034 Read with in_matrix=11: out_error and out_data_ready pulse together, out_data=0.
REQ-035 Assert in_reset during GATHER of a row read: no ready pulse; a subsequent read of any row returns 0.
